gcd_controller: RTL and testbench

//  Control FSM for the 8-bit GCD datapath; sits directly upstream of it and drives its

---
 rtl/gcd_controller.sv | 128 ++++++++++++
 tb/tb_gcd_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for an 8-bit subtractive GCD datapath (go/busy/done handshake, bounded iterations).
// Latency: go sampled in IDLE at edge 0; with S subtract steps done is high in cycle 2S+4 (abort: 2S+3).
// Backpressure: enable=0 freezes state/iter/err and forces all load strobes low; decoded flags hold.
//
// Ports: clk, reset (async active-low), enable, go, x_lt_y/x_neq_y (datapath status) in;
//        x_ld/y_ld/x_sel/y_sel/d_o_ld (datapath strobes), busy, done, err out;
//        cycles[15:0] out only when GCD_CYCLE_COUNT_EN is defined (run length LOAD..OUT, enabled cycles).
module gcd_controller #(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        go,
    input  logic        x_lt_y,
    input  logic        x_neq_y,
    output logic        x_ld,
    output logic        y_ld,
    output logic        x_sel,
    output logic        y_sel,
    output logic        d_o_ld,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [15:0] cycles
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] SUB_X = 3'd3;
    localparam logic [2:0] SUB_Y = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ITER_W-1:0] iter;
    logic              iter_max;

    assign iter_max = (iter == ITER_W'(MAX_ITER));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go) state_nxt = LOAD;
            LOAD:  state_nxt = CHECK;
            CHECK: begin
                if (!x_neq_y)     state_nxt = OUT;
                else if (iter_max) state_nxt = DONE;
                else if (x_lt_y)  state_nxt = SUB_Y;
                else              state_nxt = SUB_X;
            end
            SUB_X: state_nxt = CHECK;
            SUB_Y: state_nxt = CHECK;
            OUT:   state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            iter  <= '0;
            err   <= 1'b0;
        end else if (enable) begin
            state <= state_nxt;
            case (state)
                // err from the previous run stays visible until a new run is accepted
                IDLE:  if (go) err <= 1'b0;
                LOAD:  iter <= '0;
                CHECK: if (x_neq_y && iter_max) err <= 1'b1;
                // CHECK aborts at MAX_ITER before another step, so iter cannot wrap
                SUB_X, SUB_Y: iter <= iter + ITER_W'(1);
                default: ;
            endcase
        end
    end

    // Moore decode; loads are additionally gated by enable so a stall never clocks the datapath.
    always_comb begin
        x_ld   = 1'b0;
        y_ld   = 1'b0;
        x_sel  = 1'b0;
        y_sel  = 1'b0;
        d_o_ld = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            LOAD:  begin x_ld = enable; y_ld = enable; busy = 1'b1; end
            CHECK: busy = 1'b1;
            SUB_X: begin x_ld = enable; x_sel = 1'b1; busy = 1'b1; end
            SUB_Y: begin y_ld = enable; y_sel = 1'b1; busy = 1'b1; end
            OUT:   begin d_o_ld = enable; busy = 1'b1; end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // cnt counts the LOAD cycle itself, so a run with no subtract steps reports 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            cycles <= '0;
        end else if (enable) begin
            case (state)
                LOAD:                cnt <= 16'd1;
                CHECK, SUB_X, SUB_Y: cnt <= cnt_inc;
                default: ;
            endcase
            // includes the final CHECK or OUT cycle that leads into DONE
            if (state != DONE && state_nxt == DONE) cycles <= cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Testbench for gcd_controller: behavioural GCD datapath plus randomized runs checked
// against an arithmetic reference model.
module tb_gcd_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       go = 1'b0;
    logic       x_lt_y, x_neq_y;
    logic       x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif

    logic [7:0] x_i = 8'd0, y_i = 8'd0;
    logic [7:0] xr = 8'd0, yr = 8'd0, d_o = 8'd0;

    int checks = 0;
    int errors = 0;

    gcd_controller dut (
        .clk(clk), .reset(reset), .enable(enable), .go(go),
        .x_lt_y(x_lt_y), .x_neq_y(x_neq_y),
        .x_ld(x_ld), .y_ld(y_ld), .x_sel(x_sel), .y_sel(y_sel),
        .d_o_ld(d_o_ld), .busy(busy), .done(done), .err(err)
`ifdef GCD_CYCLE_COUNT_EN
        , .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    // Datapath the controller is meant to drive.
    always @(posedge clk) begin
        if (x_ld)   xr  <= x_sel ? xr - yr : x_i;
        if (y_ld)   yr  <= y_sel ? yr - xr : y_i;
        if (d_o_ld) d_o <= xr;
    end
    assign x_lt_y  = (xr < yr);
    assign x_neq_y = (xr != yr);

    // Reference: subtractive GCD by plain arithmetic, aborting after 255 steps.
    task automatic ref_model(input int a, input int b, output int steps, output bit abort,
                             output int g);
        steps = 0; abort = 0;
        while (a != b) begin
            if (steps == 255) begin abort = 1; break; end
            if (a < b) b = b - a; else a = a - b;
            steps++;
        end
        g = a;
    endtask

    task automatic start_go();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    // One complete run from IDLE; optional 3-cycle enable stall in the first SUB_X.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input bit stall);
        int s, g, k, dld_cyc, exp_done, stall_bad;
        bit ab, stalled;
        logic [7:0] d_prev;
        ref_model(int'(a), int'(b), s, ab, g);
        d_prev = d_o;
        x_i = a; y_i = b;
        start_go();
        k = 1; dld_cyc = -1; stalled = 0; stall_bad = 0;
        while (!done && k < 2000) begin
            if (d_o_ld) dld_cyc = k;
            if (stall && !stalled && x_sel && x_ld) begin
                stalled = 1;
                enable = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    if (x_ld || y_ld || d_o_ld || !x_sel || !busy) stall_bad++;
                    @(posedge clk); #1;
                    k++;
                end
                enable = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        exp_done = ab ? 2 * s + 3 : 2 * s + 4 + ((stall && stalled) ? 3 : 0);
        checks++;
        if (k !== exp_done) begin
            errors++;
            $display("FAIL done_cycle a=%0d b=%0d got %0d expected %0d", a, b, k, exp_done);
        end
        checks++;
        if (err !== ab) begin
            errors++;
            $display("FAIL err a=%0d b=%0d got %0b expected %0b", a, b, err, ab);
        end
        checks++;
        if (dld_cyc !== (ab ? -1 : exp_done - 1)) begin
            errors++;
            $display("FAIL d_o_ld_cycle a=%0d b=%0d got %0d expected %0d", a, b, dld_cyc,
                     ab ? -1 : exp_done - 1);
        end
        checks++;
        if (d_o !== (ab ? d_prev : 8'(g))) begin
            errors++;
            $display("FAIL d_o a=%0d b=%0d got %0d expected %0d", a, b, d_o,
                     ab ? d_prev : 8'(g));
        end
        if (stall) begin
            checks++;
            if (!stalled || stall_bad != 0) begin
                errors++;
                $display("FAIL stall a=%0d b=%0d stalled=%0b bad_cycles=%0d expected 1/0",
                         a, b, stalled, stall_bad);
            end
        end
`ifdef GCD_CYCLE_COUNT_EN
        checks++;
        if (cycles !== 16'(ab ? 2 * s + 2 : 2 * s + 3)) begin
            errors++;
            $display("FAIL cycles a=%0d b=%0d got %0d expected %0d", a, b, cycles,
                     ab ? 2 * s + 2 : 2 * s + 3);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_done a=%0d b=%0d done=%0b busy=%0b expected 0 0", a, b, done, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000000",
                     {x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err});
        end
`ifdef GCD_CYCLE_COUNT_EN
        checks++;
        if (cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_cycles got %0d expected 0", cycles);
        end
`endif
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_one(8'd12, 8'd8, 1'b0);
        run_one(8'd9, 8'd9, 1'b0);
        run_one(8'd0, 8'd5, 1'b0);
        run_one(8'd255, 8'd1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++)
            run_one(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
    endtask

    task automatic test_stall();
        run_one(8'd12, 8'd8, 1'b1);
        run_one(8'd200, 8'd30, 1'b1);
    endtask

    task automatic test_reset_mid();
        x_i = 8'd50; y_i = 8'd20;
        start_go();            // cycle 1: LOAD
        @(posedge clk); #1;    // cycle 2: CHECK
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %0b expected 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err} !== 8'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b expected 00000000",
                     {x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_one(8'd36, 8'd24, 1'b0);
    endtask

    task automatic test_back_to_back();
        int s, g, k;
        bit ab;
        ref_model(20, 15, s, ab, g);
        x_i = 8'd20; y_i = 8'd15;
        go = 1'b1;
        @(posedge clk); #1;
        k = 1;
        while (!done && k < 2000) begin @(posedge clk); #1; k++; end
        checks++;
        if (k !== 2 * s + 4) begin
            errors++;
            $display("FAIL b2b_done_cycle got %0d expected %0d", k, 2 * s + 4);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy got %0b expected 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || x_ld !== 1'b1 || y_ld !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart busy/x_ld/y_ld got %0b%0b%0b expected 111", busy, x_ld, y_ld);
        end
        go = 1'b0;
        k = 0;
        while (!done && k < 2000) begin @(posedge clk); #1; k++; end
        checks++;
        if (!done || d_o !== 8'(g)) begin
            errors++;
            $display("FAIL b2b_second_run done=%0b d_o=%0d expected 1 %0d", done, d_o, g);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
